tmr_fault_monitor: RTL and testbench

Checker that consumes the three replica outputs of a TMR processing element and produces the majority-voted result. It localizes the disagreeing replica and keeps per-replica error counts. A replica that disagrees persistently is retired from voting and a repair request is raised. It sits between the PE triplicate and the array's downstream datapath and BISR controller, and it observes the faults that the fault-injection bus creates.

---
 rtl/tmr_fault_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor
//   Majority voter and fault tracker for a triplicated processing element.
//   Each replica word is {right, bottom}; the voter picks the majority among
//   the replicas that have not been retired, blames a lone dissenter, and a
//   per-replica tracker retires a replica after PERSIST_THRESH consecutive
//   blamed samples. All outputs are registered (1-cycle latency).
// Ports:
//   clk, rst (async, active-low)
//   valid_in, clear_in                 sample valid / clear of trackers
//   rep_right_in, rep_bottom_in        replica i in [i*WORD_SIZE +: WORD_SIZE]
//   voted_right_out, voted_bottom_out  voted words (hold when no sample)
//   voted_valid_out                    valid_in delayed one cycle
//   fault_flag_out, faulty_rep_out     lone dissenter and its index (3 = none)
//   rep_fault_latched_out              retired replicas
//   double_fault_out                   no majority among active replicas
//   repair_req_out                     one-cycle pulse on retirement
//   err_cnt_out                        saturating per-replica blame counters

// Per-replica streak / retirement tracker.
module tmr_rep_tracker #(
  parameter int PERSIST_THRESH = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 blame,   // already gated by valid and active
  input  logic                 agree,   // already gated by valid and active
  output logic                 latched,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] cnt
);
  localparam int SW = $clog2(PERSIST_THRESH + 1);
  localparam logic [SW-1:0] LAST = SW'(PERSIST_THRESH - 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULTY} state_t;

  state_t         state, state_nx;
  logic [SW-1:0]  streak, streak_nx;
  logic [CNT_WIDTH-1:0] cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_OK;
      streak <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    cnt_nx    = cnt;
    retire    = 1'b0;
    if (clear) begin
      state_nx  = ST_OK;
      streak_nx = '0;
      cnt_nx    = '0;
    end else begin
      case (state)
        ST_OK: begin
          if (blame) begin
            state_nx  = ST_SUSPECT;
            streak_nx = SW'(1);
          end
        end
        ST_SUSPECT: begin
          if (blame) begin
            if (streak == LAST) begin
              state_nx = ST_FAULTY;
              retire   = 1'b1;
            end else begin
              streak_nx = streak + SW'(1);
            end
          end else if (agree) begin
            state_nx  = ST_OK;
            streak_nx = '0;
          end
        end
        default: ;  // ST_FAULTY is sticky; counter and streak frozen
      endcase
      if (blame && state != ST_FAULTY && cnt != '1)
        cnt_nx = cnt + CNT_WIDTH'(1);
    end
  end

  assign latched = (state == ST_FAULTY);
endmodule

module tmr_fault_monitor #(
  parameter int WORD_SIZE      = 16,
  parameter int PERSIST_THRESH = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   clear_in,
  input  logic [3*WORD_SIZE-1:0] rep_right_in,
  input  logic [3*WORD_SIZE-1:0] rep_bottom_in,
  output logic [WORD_SIZE-1:0]   voted_right_out,
  output logic [WORD_SIZE-1:0]   voted_bottom_out,
  output logic                   voted_valid_out,
  output logic                   fault_flag_out,
  output logic [1:0]             faulty_rep_out,
  output logic [2:0]             rep_fault_latched_out,
  output logic                   double_fault_out,
  output logic                   repair_req_out,
  output logic [3*CNT_WIDTH-1:0] err_cnt_out
);
  localparam int DW = 2 * WORD_SIZE;

  logic [2:0][DW-1:0] w;
  logic [2:0]         act, blame, agree, retire, latched;
  logic [DW-1:0]      vote;
  logic [1:0]         odd, lo, hi;
  logic               dbl, few_act;

  for (genvar i = 0; i < 3; i++) begin : g_rep
    assign w[i] = {rep_right_in[i*WORD_SIZE +: WORD_SIZE],
                   rep_bottom_in[i*WORD_SIZE +: WORD_SIZE]};

    tmr_rep_tracker #(
      .PERSIST_THRESH(PERSIST_THRESH),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_trk (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_in),
      .blame  (blame[i]),
      .agree  (agree[i]),
      .latched(latched[i]),
      .retire (retire[i]),
      .cnt    (err_cnt_out[i*CNT_WIDTH +: CNT_WIDTH])
    );

    // A replica agrees only when a real majority exists and it matches it.
    assign agree[i] = valid_in & act[i] & ~dbl & (w[i] == vote);
    assign blame[i] = valid_in & (odd == 2'(i));
  end

  // During a clear every replica votes again, since the latches drop this edge.
  assign act     = clear_in ? 3'b111 : ~latched;
  assign few_act = ~((act[0] & act[1]) | (act[0] & act[2]) | (act[1] & act[2]));

  always_comb begin
    vote = w[0];
    odd  = 2'b11;
    dbl  = 1'b0;
    lo   = 2'd0;
    hi   = 2'd1;
    case (act)
      3'b111: begin
        if (w[0] == w[1]) begin
          vote = w[0];
          if (w[0] != w[2]) odd = 2'd2;
        end else if (w[0] == w[2]) begin
          vote = w[0];
          odd  = 2'd1;
        end else if (w[1] == w[2]) begin
          vote = w[1];
          odd  = 2'd0;
        end else begin
          dbl = 1'b1;
        end
      end
      3'b011, 3'b101, 3'b110: begin
        // With two voters a disagreement cannot be attributed.
        lo   = act[0] ? 2'd0 : 2'd1;
        hi   = act[2] ? 2'd2 : 2'd1;
        vote = w[lo];
        dbl  = (w[lo] != w[hi]);
      end
      3'b010:  begin vote = w[1]; dbl = 1'b1; end
      3'b100:  begin vote = w[2]; dbl = 1'b1; end
      default: begin vote = w[0]; dbl = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voted_right_out  <= '0;
      voted_bottom_out <= '0;
      voted_valid_out  <= 1'b0;
      fault_flag_out   <= 1'b0;
      faulty_rep_out   <= 2'b11;
      double_fault_out <= 1'b0;
      repair_req_out   <= 1'b0;
    end else if (valid_in) begin
      voted_right_out  <= vote[DW-1:WORD_SIZE];
      voted_bottom_out <= vote[WORD_SIZE-1:0];
      voted_valid_out  <= 1'b1;
      fault_flag_out   <= (odd != 2'b11);
      faulty_rep_out   <= odd;
      double_fault_out <= dbl;
      repair_req_out   <= |retire;  // trackers never retire during a clear
    end else begin
      voted_valid_out  <= 1'b0;
      fault_flag_out   <= 1'b0;
      faulty_rep_out   <= 2'b11;
      double_fault_out <= few_act;
      repair_req_out   <= 1'b0;
    end
  end

  assign rep_fault_latched_out = latched;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
module tb_tmr_fault_monitor;
  localparam int WS = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic          clear_in = 1'b0;
  logic [3*WS-1:0] rep_right_in = '0;
  logic [3*WS-1:0] rep_bottom_in = '0;
  logic [WS-1:0] voted_right_out, voted_bottom_out;
  logic          voted_valid_out, fault_flag_out, double_fault_out, repair_req_out;
  logic [1:0]    faulty_rep_out;
  logic [2:0]    rep_fault_latched_out;
  logic [3*CW-1:0] err_cnt_out;

  int total = 0;
  int bad   = 0;

  tmr_fault_monitor #(.WORD_SIZE(WS), .PERSIST_THRESH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .clear_in(clear_in),
    .rep_right_in(rep_right_in), .rep_bottom_in(rep_bottom_in),
    .voted_right_out(voted_right_out), .voted_bottom_out(voted_bottom_out),
    .voted_valid_out(voted_valid_out), .fault_flag_out(fault_flag_out),
    .faulty_rep_out(faulty_rep_out), .rep_fault_latched_out(rep_fault_latched_out),
    .double_fault_out(double_fault_out), .repair_req_out(repair_req_out),
    .err_cnt_out(err_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WS-1:0] r0, r1, r2,
                       input logic [WS-1:0] b0, b1, b2);
    valid_in      = v;
    rep_right_in  = {r2, r1, r0};
    rep_bottom_in = {b2, b1, b0};
  endtask

  // Apply the current inputs across one rising edge; outputs settle by +1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [WS-1:0] vr, vb,
                         input logic vv, ff, input logic [1:0] fr,
                         input logic [2:0] lat, input logic df, rq,
                         input logic [3*CW-1:0] cnt);
    chk({tag, ".right"},  64'(voted_right_out),  64'(vr));
    chk({tag, ".bottom"}, 64'(voted_bottom_out), 64'(vb));
    chk({tag, ".valid"},  64'(voted_valid_out),  64'(vv));
    chk({tag, ".flag"},   64'(fault_flag_out),   64'(ff));
    chk({tag, ".rep"},    64'(faulty_rep_out),   64'(fr));
    chk({tag, ".latch"},  64'(rep_fault_latched_out), 64'(lat));
    chk({tag, ".dbl"},    64'(double_fault_out), 64'(df));
    chk({tag, ".repair"}, 64'(repair_req_out),   64'(rq));
    chk({tag, ".cnt"},    64'(err_cnt_out),      64'(cnt));
  endtask

  initial begin
    // Reset state
    drive(1'b1, 16'd2, 16'd2, 16'd2, 16'd6, 16'd6, 16'd6);
    #12;
    chk_out("reset", 0, 0, 0, 0, 2'b11, 3'b000, 0, 0, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Clean operation
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("clean", 2, 6, 1, 0, 2'b11, 3'b000, 0, 0, 24'h0);
    end

    // Transient fault on replica 1
    drive(1'b1, 16'd2, 16'd2, 16'd2, 16'd6, 16'd7, 16'd6);
    cyc();
    chk_out("transient", 2, 6, 1, 1, 2'd1, 3'b000, 0, 0, 24'h000100);
    drive(1'b1, 16'd2, 16'd2, 16'd2, 16'd6, 16'd6, 16'd6);
    cyc();
    chk_out("transient.after", 2, 6, 1, 0, 2'b11, 3'b000, 0, 0, 24'h000100);

    // Persistent fault on replica 0 with a gap after the 2nd sample
    drive(1'b1, 16'd9, 16'd2, 16'd2, 16'd6, 16'd6, 16'd6);
    cyc();
    chk_out("persist1", 2, 6, 1, 1, 2'd0, 3'b000, 0, 0, 24'h000101);
    cyc();
    chk_out("persist2", 2, 6, 1, 1, 2'd0, 3'b000, 0, 0, 24'h000102);
    valid_in = 1'b0;
    cyc();
    chk_out("gap", 2, 6, 0, 0, 2'b11, 3'b000, 0, 0, 24'h000102);
    valid_in = 1'b1;
    cyc();
    chk_out("persist3", 2, 6, 1, 1, 2'd0, 3'b000, 0, 0, 24'h000103);
    cyc();
    chk_out("persist4", 2, 6, 1, 1, 2'd0, 3'b001, 0, 1, 24'h000104);
    cyc();
    chk_out("retired", 2, 6, 1, 0, 2'b11, 3'b001, 0, 0, 24'h000104);

    // Post-retire double fault: only replicas 1 and 2 vote
    drive(1'b1, 16'd9, 16'd5, 16'd2, 16'd6, 16'd6, 16'd6);
    cyc();
    chk_out("post_retire", 5, 6, 1, 0, 2'b11, 3'b001, 1, 0, 24'h000104);

    // Clear: trackers reset, replica 0 votes again
    clear_in = 1'b1;
    drive(1'b1, 16'd9, 16'd2, 16'd2, 16'd6, 16'd6, 16'd6);
    cyc();
    clear_in = 1'b0;
    chk_out("clear", 2, 6, 1, 1, 2'd0, 3'b000, 0, 0, 24'h0);

    // Three-way disagreement
    drive(1'b1, 16'd1, 16'd2, 16'd3, 16'd6, 16'd6, 16'd6);
    cyc();
    chk_out("three_way", 1, 6, 1, 0, 2'b11, 3'b000, 1, 0, 24'h0);

    // Reset mid-streak on replica 2
    drive(1'b1, 16'd2, 16'd2, 16'd7, 16'd6, 16'd6, 16'd6);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk_out("streak_pre", 2, 6, 1, 1, 2'd2, 3'b000, 0, 0, 24'(i << 16));
    end
    #2;
    rst = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0, 0, 2'b11, 3'b000, 0, 0, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk_out("streak_post", 2, 6, 1, 1, 2'd2, 3'b000, 0, 0, 24'(i << 16));
    end
    cyc();
    chk_out("streak_retire", 2, 6, 1, 1, 2'd2, 3'b100, 0, 1, 24'h040000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
